// File: rtl/bcd_timer.sv
// Mixed-radix BCD up/down timer with preset load, lap capture, wrap and expiry pulses.
// Latency: tick, wrap and the new time_reading share the edge after the divider reaches TICK_DIV-1.
// No backpressure: strobes are one-cycle and always accepted; outputs are registered pulses.
module bcd_timer #(
    parameter int TICK_DIV = 100000000,
    parameter int DIGITS   = 4,
    parameter int MINSEC   = 1
) (
    input  logic                clk,
    input  logic                init_regs_n,
    input  logic                run,
    input  logic                dir,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    input  logic                lap,
    output logic [4*DIGITS-1:0] time_reading,
    output logic [4*DIGITS-1:0] lap_reading,
    output logic                lap_valid,
    output logic                tick,
    output logic                wrap,
    output logic                expired
);

    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   div, div_nxt;
    logic            step;
    logic            expire_now;
    logic            all_zero;

    function automatic logic [3:0] digit_max(input int i);
        return (MINSEC != 0 && (i % 2) == 1) ? 4'd5 : 4'd9;
    endfunction

    // Ripple carry (up) or borrow (down) through the digit chain.
    function automatic logic [DW-1:0] bcd_step(input logic [DW-1:0] v, input logic down);
        logic          c;
        logic [3:0]    d;
        logic [DW-1:0] r;
        c = 1'b1;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (!down) begin
                    if (d >= digit_max(i)) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        r[4*i +: 4] = digit_max(i);
                    end else begin
                        r[4*i +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic all_max(input logic [DW-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != digit_max(i)) r = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] clamp(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > digit_max(i)) r[4*i +: 4] = digit_max(i);
        end
        return r;
    endfunction

    assign all_zero = (time_reading == '0);

    always_comb begin
        state_nxt  = state;
        div_nxt    = div;
        step       = 1'b0;
        expire_now = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_RUN;
            end
            S_RUN: begin
                // Expiry pre-empts any decrement; the divider simply holds.
                if (dir && all_zero) begin
                    state_nxt  = S_EXPIRED;
                    expire_now = 1'b1;
                end else begin
                    if (div == CW'(TICK_DIV - 1)) begin
                        div_nxt = '0;
                        step    = 1'b1;
                    end else begin
                        div_nxt = div + CW'(1);
                    end
                    if (!run) state_nxt = S_IDLE;
                end
            end
            S_EXPIRED: begin
                state_nxt = S_EXPIRED;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (load) begin
            state_nxt  = S_IDLE;
            div_nxt    = '0;
            step       = 1'b0;
            expire_now = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!init_regs_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!init_regs_n) begin
            div          <= '0;
            time_reading <= '0;
            lap_reading  <= '0;
            lap_valid    <= 1'b0;
            tick         <= 1'b0;
            wrap         <= 1'b0;
            expired      <= 1'b0;
        end else begin
            div     <= div_nxt;
            tick    <= step;
            wrap    <= step & ~dir & all_max(time_reading);
            expired <= expire_now;
            if (load) begin
                time_reading <= clamp(load_value);
            end else if (step) begin
                time_reading <= bcd_step(time_reading, dir);
            end
            // Lap samples the pre-edge reading, independent of load or step.
            if (lap) begin
                lap_reading <= time_reading;
                lap_valid   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/bcd_timer.md
Name: bcd_timer

Overview:
- Parametrised successor to the two-digit seconds counter: DIGITS BCD digits, mixed radix (optional mm:ss), configurable tick divider.
- Counts up or down, with synchronous preset load, lap capture, wrap and expiry pulses.
- Sits between the control FSM (run/load/lap strobes) and the seven-segment display driver.

Parameters:
TICK_DIV, 100000000, clk cycles per LSD step (1 s at 100 MHz); must be >= 2
DIGITS, 4, number of BCD digits (2..8)
MINSEC, 1, 1: odd-index digits (1, 3, ...) are radix 6, even-index radix 10; 0: all radix 10

Ports:
clk  in  1  system clock, all logic on posedge
init_regs_n  in  1  synchronous active-low reset
run  in  1  level; 1 = count
dir  in  1  0 = up, 1 = down; sampled on each tick
load  in  1  one-cycle strobe: preset digits from load_value
load_value  in  4*DIGITS  preset, digit 0 = bits [3:0]
lap  in  1  one-cycle strobe: capture current reading
time_reading  out  4*DIGITS  registered BCD count
lap_reading  out  4*DIGITS  last captured reading
lap_valid  out  1  set by first lap after reset
tick  out  1  one-cycle pulse, coincident with each digit update
wrap  out  1  one-cycle pulse on up-count rollover of all digits
expired  out  1  one-cycle pulse on entry to EXPIRED

Behaviour:
- Reset (init_regs_n=0 at posedge):
  - Priority over everything.
  - Divider, digits, time_reading, lap_reading, lap_valid, tick, wrap and expired all go to 0; state goes to IDLE.
- Priority per edge: reset > load > count. Lap capture happens in parallel with load or count.
- States:
  - IDLE: run=1 -> RUN.
  - RUN: run=0 -> IDLE. dir=1 and all digits 0 -> EXPIRED; expired=1 for one cycle; no decrement.
  - EXPIRED: counting frozen, run ignored. Exits only via load -> IDLE, or reset.
  - load in any state -> IDLE.
- Divider:
  - Counts 0..TICK_DIV-1 only in RUN. On reaching TICK_DIV-1 it returns to 0 and a tick step occurs.
  - Leaving RUN holds the divider value, so pause/resume keeps the sub-tick fraction.
  - load clears the divider.
- Tick step, up (dir=0):
  - Digit 0 increments; a digit at radix-1 goes to 0 and carries to the next digit.
  - All digits at max -> all 0 and wrap=1 in the same cycle.
- Tick step, down (dir=1):
  - Digit 0 decrements; a digit at 0 goes to radix-1 and borrows from the next digit.
  - A result of all-zero does not expire on this edge. Expiry happens on the following RUN cycle per the state rule, so expired lags the zero reading by 1 cycle.
  - Down-count never wraps.
- tick/time_reading latency:
  - tick and the new time_reading appear at the same edge (1 cycle after the divider reaches TICK_DIV-1).
  - tick, wrap and expired are registered and low in all other cycles.
- load:
  - Each digit is clamped to radix-1 if illegal (e.g. 0xF on a radix-6 digit -> 5).
  - A tick coincident with load is discarded.
- lap:
  - Captures the pre-edge time_reading; with a coincident tick or load, the pre-update value is taken.
  - Sets lap_valid, which stays 1 until reset.
  - lap_reading is unaffected by load.
- dir change mid-run: applies to the next tick only; the divider is not disturbed.
- run deasserted on the same edge the divider reaches TICK_DIV-1: the tick step still occurs (it is evaluated from the registered RUN state); the next state is IDLE.

Test Plan (TICK_DIV=4, DIGITS=4, MINSEC=1):
1. init_regs_n=0 for 2 cycles with run=1, load=1 -> all outputs 0, state IDLE. Release with run=1 -> first tick 4 cycles later, time_reading=16'h0001.
2. Up from 0, run=1 for 240 cycles -> reading passes 16'h0059 then 16'h0100 (carry through radix-6 s10). 60 tick pulses, no wrap.
3. load 16'h5959, run up -> after 4 cycles reading=16'h0000 and wrap=1 for exactly 1 cycle, coincident with tick.
4. load 16'h0002, dir=1, run -> 16'h0001 at cycle 4, 16'h0000 at cycle 8, expired=1 at cycle 9. Reading holds 0 for 20 further cycles. Then load 16'h0010 -> IDLE, and run counts down to 16'h0009.
5. Pause and lap:
  - Drop run at divider=2 for 10 cycles, then resume -> next tick 1 RUN cycle later.
  - Assert lap on a tick edge with reading 16'h0007 -> lap_reading=16'h0007, time_reading=16'h0008, lap_valid=1.
6. load 16'h0A7F -> reading 16'h0959 (clamp). Reset asserted mid-count at divider=3 -> no tick; all registers 0 on that edge.
